// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared opcodes, flag indices, FSM states and constants for fp_issue_queue
package fp_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b100;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Flags reported for an opcode completed without the ALU
    localparam logic [4:0] FLAGS_LOCAL = 5'b1 << FLAG_NV;

    // Canonical quiet NaN for the default single-precision format
    localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_LOCAL = 2'd3
    } state_t;

    // Opcodes the downstream ALU implements; everything else is finished locally
    function automatic logic op_supported(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/fp_req_fifo.sv
// rtl/fp_req_fifo.sv - synchronous request FIFO with push/pop and occupancy count
module fp_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage write; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; caller never pushes when full nor pops when empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fp_issue_queue.sv
// rtl/fp_issue_queue.sv - request buffer and one-at-a-time sequencer in front of float_alu
module fp_issue_queue
    import fp_pkg::*;
#(
    parameter int P     = 23,
    parameter int E     = 8,
    parameter int N     = P + E + 1,
    parameter int DEPTH = 4,
    parameter int TW    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [N-1:0]           req_a,
    input  logic [N-1:0]           req_b,
    input  logic [2:0]             req_op,
    input  logic                   req_mode_fp,
    input  logic                   req_round,
    input  logic [TW-1:0]          req_tag,
    output logic [N-1:0]           alu_op_a,
    output logic [N-1:0]           alu_op_b,
    output logic [2:0]             alu_op_code,
    output logic                   alu_mode_fp,
    output logic                   alu_round_mode,
    output logic                   alu_start,
    output logic                   alu_ready_in,
    input  logic                   alu_ready_out,
    input  logic                   alu_valid_out,
    input  logic [N-1:0]           alu_result,
    input  logic [4:0]             alu_flags,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [N-1:0]           res_data,
    output logic [4:0]             res_flags,
    output logic [TW-1:0]          res_tag,
    output logic [4:0]             sticky_flags,
    input  logic                   sticky_clr,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = TW + 2 + 3 + 2 * N;
    localparam logic [N-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(P-1){1'b0}}};

    state_t          state;
    state_t          state_nxt;
    logic [FW-1:0]   fifo_wdata;
    logic [FW-1:0]   fifo_rdata;
    logic            push;
    logic            pop;
    logic [N-1:0]    head_a;
    logic [N-1:0]    head_b;
    logic [2:0]      head_op;
    logic            head_mode;
    logic            head_round;
    logic [TW-1:0]   head_tag;
    logic [TW-1:0]   iss_tag;
    logic            out_free;
    logic            cap_alu;
    logic            cap_local;
    logic            capture;
    logic [N-1:0]    cap_data;
    logic [4:0]      cap_flags;

    assign req_ready  = (count != CW'(DEPTH));
    assign push       = req_valid && req_ready;
    assign pop        = (state == ST_IDLE) && (count != '0);
    assign fifo_wdata = {req_tag, req_round, req_mode_fp, req_op, req_b, req_a};
    assign {head_tag, head_round, head_mode, head_op, head_b, head_a} = fifo_rdata;

    fp_req_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (count)
    );

    // Output register is free when empty or being drained this cycle
    assign out_free     = !res_valid || res_ready;
    assign alu_start    = (state == ST_ISSUE);
    assign alu_ready_in = (state == ST_WAIT) && out_free;
    assign cap_alu      = alu_ready_in && alu_valid_out;
    assign cap_local    = (state == ST_LOCAL) && out_free;
    assign capture      = cap_alu || cap_local;
    assign cap_data     = cap_local ? QNAN : alu_result;
    assign cap_flags    = cap_local ? FLAGS_LOCAL : alu_flags;

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: pop in IDLE, route to ALU or local completion, return after capture
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pop) state_nxt = op_supported(head_op) ? ST_ISSUE : ST_LOCAL;
            ST_ISSUE: if (alu_ready_out) state_nxt = ST_WAIT;
            ST_WAIT:  if (cap_alu) state_nxt = ST_IDLE;
            ST_LOCAL: if (cap_local) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Issue register: loaded only on pop so ALU inputs hold through ISSUE and WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_op_a       <= '0;
            alu_op_b       <= '0;
            alu_op_code    <= '0;
            alu_mode_fp    <= 1'b0;
            alu_round_mode <= 1'b0;
            iss_tag        <= '0;
        end else if (pop) begin
            alu_op_a       <= head_a;
            alu_op_b       <= head_b;
            alu_op_code    <= head_op;
            alu_mode_fp    <= head_mode;
            alu_round_mode <= head_round;
            iss_tag        <= head_tag;
        end
    end

    // Output register: a capture wins over a same-cycle drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_flags <= '0;
            res_tag   <= '0;
        end else if (capture) begin
            res_valid <= 1'b1;
            res_data  <= cap_data;
            res_flags <= cap_flags;
            res_tag   <= iss_tag;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

    // Sticky exception flags; a clear coinciding with a capture keeps only the new flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_flags <= '0;
        end else if (capture) begin
            sticky_flags <= (sticky_clr ? 5'b0 : sticky_flags) | cap_flags;
        end else if (sticky_clr) begin
            sticky_flags <= '0;
        end
    end

endmodule

// File: tb/tb_fp_issue_queue.sv
// tb/tb_fp_issue_queue.sv - self-checking bench for fp_issue_queue with stub ALU and queue model
module tb_fp_issue_queue;
    import fp_pkg::*;

    localparam int P = 23, E = 8, N = 32, DEPTH = 4, TW = 4;

    logic clk, rst;
    logic req_valid, req_ready, req_mode_fp, req_round;
    logic [N-1:0] req_a, req_b;
    logic [2:0] req_op;
    logic [TW-1:0] req_tag;
    logic [N-1:0] alu_op_a, alu_op_b, alu_result;
    logic [2:0] alu_op_code;
    logic alu_mode_fp, alu_round_mode, alu_start, alu_ready_in, alu_ready_out, alu_valid_out;
    logic [4:0] alu_flags, res_flags, sticky_flags;
    logic res_valid, res_ready, sticky_clr;
    logic [N-1:0] res_data;
    logic [TW-1:0] res_tag;
    logic [2:0] count;

    fp_issue_queue #(.P(P), .E(E), .N(N), .DEPTH(DEPTH), .TW(TW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_mode_fp(req_mode_fp),
        .req_round(req_round), .req_tag(req_tag), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
        .alu_op_code(alu_op_code), .alu_mode_fp(alu_mode_fp), .alu_round_mode(alu_round_mode),
        .alu_start(alu_start), .alu_ready_in(alu_ready_in), .alu_ready_out(alu_ready_out),
        .alu_valid_out(alu_valid_out), .alu_result(alu_result), .alu_flags(alu_flags),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_flags(res_flags),
        .res_tag(res_tag), .sticky_flags(sticky_flags), .sticky_clr(sticky_clr), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  flg;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] res;
        logic [4:0]  flg;
        int          lat;
    } vec_t;

    // Stub ALU behaviour: 1.0 + 2.0 gives 3.0, otherwise a simple mix of operands
    function automatic logic [36:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000 && op == OP_ADD) return {32'h4040_0000, 5'b0};
        return {a ^ b ^ {29'b0, op}, b[4:0]};
    endfunction

    function automatic exp_t expect_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        exp_t e;
        logic [36:0] r;
        if (op <= 3'd2) begin
            r = alu_model(a, b, op);
            e.res = r[36:5];
            e.flg = r[4:0];
        end else begin
            e.res = QNAN_SP;
            e.flg = 5'b10000;
        end
        e.tag = tag;
        return e;
    endfunction

    // Stub ALU plus reference model, all decided half a cycle before each rising edge
    exp_t exp_q[$];
    logic [4:0] sticky_m;
    int drained = 0, start_cnt = 0;
    bit stub_ready_en, stub_rand;
    int stub_lat;
    logic stub_busy, stub_valid, hs_start, hs_done;
    int stub_cnt;
    logic [31:0] stub_a, stub_res;
    logic [2:0] stub_op;
    logic [4:0] stub_flg;

    initial begin : stub
        exp_t e;
        stub_busy = 0; stub_valid = 0; hs_start = 0; hs_done = 0; stub_cnt = 0;
        stub_a = 0; stub_op = 0; stub_res = 0; stub_flg = 0; sticky_m = 0;
        alu_valid_out = 0; alu_result = 0; alu_flags = 0; alu_ready_out = 0;
        forever begin
            @(negedge clk);
            if (hs_done) begin stub_busy = 0; stub_valid = 0; end
            if (hs_start) begin
                stub_busy = 1; stub_valid = 0;
                stub_cnt = stub_rand ? int'($urandom_range(0, 3)) : stub_lat;
                stub_a = alu_op_a; stub_op = alu_op_code;
                {stub_res, stub_flg} = alu_model(alu_op_a, alu_op_b, alu_op_code);
            end
            if (stub_busy && !stub_valid) begin
                if (stub_cnt == 0) stub_valid = 1;
                else stub_cnt--;
            end
            alu_valid_out = stub_valid;
            alu_result = stub_valid ? stub_res : 32'h0;
            alu_flags = stub_valid ? stub_flg : 5'h0;
            alu_ready_out = stub_ready_en && !stub_busy;
            #1;
            if (rst) begin
                stub_busy = 0; stub_valid = 0; hs_start = 0; hs_done = 0;
                alu_valid_out = 0; alu_ready_out = stub_ready_en;
                exp_q.delete();
            end else begin
                hs_start = alu_start && alu_ready_out;
                hs_done = alu_valid_out && alu_ready_in;
                if (sticky_clr) sticky_m = 0;
                if (alu_start) begin
                    start_cnt++;
                    chk("one_in_flight", stub_busy, 0);
                end
                if (hs_start) chk("issued_op_supported", alu_op_code <= 3'd2, 1);
                if (stub_busy) begin
                    chk("op_a_stable", alu_op_a, stub_a);
                    chk("op_code_stable", alu_op_code, stub_op);
                end
                if (req_valid && req_ready) exp_q.push_back(expect_of(req_op, req_a, req_b, req_tag));
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_result: got tag %0h expected none", res_tag);
                    end else begin
                        e = exp_q.pop_front();
                        chk("model_res_data", res_data, e.res);
                        chk("model_res_flags", res_flags, e.flg);
                        chk("model_res_tag", res_tag, e.tag);
                        sticky_m |= e.flg;
                        drained++;
                    end
                end
            end
        end
    end

    task automatic push_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        int n = 0;
        req_op = op; req_a = a; req_b = b; req_tag = tag;
        req_mode_fp = 1'($urandom); req_round = 1'($urandom); req_valid = 1;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL push_timeout: got req_ready 0 expected 1");
        end
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic wait_res(input int max, output int cyc);
        cyc = 0;
        while (!res_valid && cyc < max) begin @(negedge clk); cyc++; end
        if (!res_valid) begin
            checks++; errors++;
            $display("FAIL res_timeout: got res_valid 0 expected 1");
        end
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((exp_q.size() != 0 || res_valid || count != 0 || stub_busy) && n < max) begin
            @(negedge clk); n++;
        end
        chk("idle_reached", exp_q.size() == 0 && !res_valid && count == 0, 1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs[6];
        int cyc, s0, acc, d0;
        bit r;
        logic [4:0] run_or;

        vecs[0] = '{OP_ADD, 32'h3F80_0000, 32'h4000_0000, 4'd3,  32'h4040_0000, 5'b00000, 3};
        vecs[1] = '{OP_SUB, 32'h1234_5678, 32'h0000_0010, 4'd1,  32'h1234_5669, 5'b10000, 3};
        vecs[2] = '{OP_MUL, 32'hAAAA_0000, 32'h0000_000C, 4'd2,  32'hAAAA_000E, 5'b01100, 3};
        vecs[3] = '{OP_DIV, 32'h0000_0001, 32'h0000_0002, 4'd5,  32'h7FC0_0000, 5'b10000, 2};
        vecs[4] = '{3'b011, 32'h4000_0000, 32'h0000_0000, 4'd6,  32'h7FC0_0000, 5'b10000, 2};
        vecs[5] = '{3'b111, 32'hFFFF_FFFF, 32'h1234_0000, 4'd15, 32'h7FC0_0000, 5'b10000, 2};

        rst = 1; req_valid = 1; req_a = 32'hDEAD_BEEF; req_b = 32'h1; req_op = OP_ADD;
        req_tag = 4'hA; req_mode_fp = 0; req_round = 0; res_ready = 0; sticky_clr = 0;
        stub_ready_en = 1; stub_rand = 0; stub_lat = 0;
        repeat (3) @(negedge clk);

        chk("rst_req_ready", req_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_alu_start", alu_start, 0);
        chk("rst_alu_ready_in", alu_ready_in, 0);
        chk("rst_sticky", sticky_flags, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_alu_op_a", alu_op_a, 0);
        rst = 0; req_valid = 0; res_ready = 1;
        @(negedge clk);
        chk("rst_push_discarded", count, 0);

        run_or = 0;
        for (int i = 0; i < 6; i++) begin
            s0 = start_cnt;
            push_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
            wait_res(20, cyc);
            chk("vec_latency", cyc, vecs[i].lat);
            chk("vec_res_data", res_data, vecs[i].res);
            chk("vec_res_flags", res_flags, vecs[i].flg);
            chk("vec_res_tag", res_tag, vecs[i].tag);
            if (vecs[i].op > 3'd2) chk("vec_local_no_start", start_cnt - s0, 0);
            run_or |= vecs[i].flg;
            @(negedge clk);
            chk("vec_sticky", sticky_flags, run_or);
            chk("vec_drained", res_valid, 0);
        end

        // Full FIFO with the ALU refusing starts
        wait_idle(100);
        stub_ready_en = 0;
        @(negedge clk);
        d0 = drained; acc = 0;
        req_op = OP_ADD; req_a = 32'h100; req_b = 0; req_tag = 0; req_valid = 1;
        repeat (8) begin
            r = req_ready;
            @(negedge clk);
            if (r) begin acc++; req_tag = 4'(acc); req_a = 32'h100 + acc; end
        end
        chk("full_accepted", acc, 5);
        chk("full_count", count, 4);
        chk("full_req_ready", req_ready, 0);
        chk("full_stalled_issue", alu_start, 1);
        stub_ready_en = 1;
        cyc = 0;
        while (count == 4 && cyc < 50) begin @(negedge clk); cyc++; end
        chk("full_no_push_on_pop", count, 3);
        @(negedge clk);
        req_valid = 0;
        wait_idle(200);
        chk("full_drained", drained - d0, 6);

        // Output back-pressure combined with sticky clear on capture
        sticky_clr = 1;
        @(negedge clk);
        sticky_clr = 0;
        chk("sticky_cleared", sticky_flags, 0);
        res_ready = 0;
        push_req(OP_ADD, 32'h1111_0000, 32'h4, 4'd7);
        push_req(OP_MUL, 32'h2222_0000, 32'h1, 4'd8);
        repeat (6) @(negedge clk);
        chk("bp_res_valid", res_valid, 1);
        chk("bp_res_tag", res_tag, 7);
        chk("bp_res_flags", res_flags, 5'b00100);
        chk("bp_sticky", sticky_flags, 5'b00100);
        chk("bp_alu_ready_in", alu_ready_in, 0);
        chk("bp_alu_valid_pending", alu_valid_out, 1);
        repeat (3) @(negedge clk);
        chk("bp_op_a_hold", alu_op_a, 32'h2222_0000);
        chk("bp_op_b_hold", alu_op_b, 32'h1);
        chk("bp_op_code_hold", alu_op_code, OP_MUL);
        chk("bp_still_stalled", alu_ready_in, 0);
        res_ready = 1; sticky_clr = 1;
        @(negedge clk);
        sticky_clr = 0;
        chk("bp_second_valid", res_valid, 1);
        chk("bp_second_tag", res_tag, 8);
        chk("bp_second_data", res_data, 32'h2222_0003);
        chk("sticky_clr_with_capture", sticky_flags, 5'b00001);
        @(negedge clk);
        chk("bp_both_drained", res_valid, 0);

        // Reset while an operation is in WAIT
        wait_idle(100);
        stub_lat = 30;
        push_req(OP_ADD, 32'h9, 32'h0, 4'd9);
        push_req(OP_ADD, 32'hA, 32'h0, 4'd10);
        push_req(OP_ADD, 32'hB, 32'h0, 4'd11);
        chk("mid_wait_count", count, 2);
        chk("mid_wait_ready_in", alu_ready_in, 1);
        rst = 1; req_valid = 1; req_tag = 4'd12;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_res_valid", res_valid, 0);
        chk("async_rst_ready_in", alu_ready_in, 0);
        @(negedge clk);
        chk("rst_held_count", count, 0);
        rst = 0; req_valid = 0; stub_lat = 0;
        @(negedge clk);
        push_req(OP_SUB, 32'h5, 32'h3, 4'd13);
        wait_res(20, cyc);
        chk("post_rst_latency", cyc, 3);
        chk("post_rst_tag", res_tag, 13);
        chk("post_rst_data", res_data, 32'h7);

        // Randomised traffic against the queue model
        wait_idle(100);
        sticky_clr = 1;
        @(negedge clk);
        sticky_clr = 0;
        stub_rand = 1;
        d0 = drained;
        repeat (800) begin
            @(negedge clk);
            req_valid = 1'($urandom);
            req_op = 3'($urandom);
            req_a = $urandom;
            req_b = $urandom;
            req_tag = 4'($urandom);
            req_mode_fp = 1'($urandom);
            req_round = 1'($urandom);
            res_ready = ($urandom % 4) != 0;
            stub_ready_en = ($urandom % 4) != 0;
        end
        @(negedge clk);
        req_valid = 0; res_ready = 1; stub_ready_en = 1;
        wait_idle(1000);
        chk("rand_sticky", sticky_flags, sticky_m);
        chk("rand_enough_results", (drained - d0) > 50, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
